// File: rtl/simple_wgen_pkg.sv
// Shared definitions for the simple_wgen write-data generator.
// Holds the control register map, the CTRL/STATUS bit positions and the
// generator FSM state encoding.
package simple_wgen_pkg;

   // Register select, taken from control address bits [3:2]
   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_LEN    = 2'd1;
   localparam logic [1:0] REG_SENT   = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   // CTRL write bits (self-clearing pulses)
   localparam int CTRL_START_BIT = 0;
   localparam int CTRL_ABORT_BIT = 1;

   // STATUS read bits
   localparam int STAT_BUSY_BIT    = 0;
   localparam int STAT_DONE_BIT    = 1;
   localparam int STAT_ABORTED_BIT = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

endpackage

// File: rtl/axi4l_sif.sv
// AXI4-Lite slave interface: turns AW/W/B and AR/R channel traffic into
// single-cycle register-side write strobes and read lookups.
// Ports:
//   clk, sys__srstn          clock, asynchronous active-low reset
//   s_axi_aw*/w*/b*/ar*/r*   AXI4-Lite slave, 32-bit data, no prot
//   reg_wr_en/addr/data/strb one-cycle register write (always accepted)
//   reg_rd_addr, reg_rd_data combinational register read lookup
//
// Handshake rule on every channel: a transfer happens on a rising edge
// where valid && ready are both 1; a source holds its payload stable and
// keeps valid high until that edge; ready may depend on internal state only.
module axi4l_sif #(
   parameter int addr_width = 32
) (
   input  logic                  clk,
   input  logic                  sys__srstn,
   input  logic [addr_width-1:0] s_axi_awaddr,
   input  logic                  s_axi_awvalid,
   output logic                  s_axi_awready,
   input  logic [31:0]           s_axi_wdata,
   input  logic [3:0]            s_axi_wstrb,
   input  logic                  s_axi_wvalid,
   output logic                  s_axi_wready,
   output logic [1:0]            s_axi_bresp,
   output logic                  s_axi_bvalid,
   input  logic                  s_axi_bready,
   input  logic [addr_width-1:0] s_axi_araddr,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   output logic [31:0]           s_axi_rdata,
   output logic [1:0]            s_axi_rresp,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready,
   output logic                  reg_wr_en,
   output logic [addr_width-1:0] reg_wr_addr,
   output logic [31:0]           reg_wr_data,
   output logic [3:0]            reg_wr_strb,
   output logic [addr_width-1:0] reg_rd_addr,
   input  logic [31:0]           reg_rd_data
);

   logic                  aw_full, w_full;
   logic [addr_width-1:0] aw_addr_q;
   logic [31:0]           w_data_q;
   logic [3:0]            w_strb_q;
   logic                  aw_fire, w_fire, ar_fire;

   // AW and W may arrive in either order; each is parked until its partner
   // shows up. Nothing new is accepted while a write response is pending.
   assign s_axi_awready = !aw_full && !s_axi_bvalid;
   assign s_axi_wready  = !w_full && !s_axi_bvalid;
   assign aw_fire       = s_axi_awvalid && s_axi_awready;
   assign w_fire        = s_axi_wvalid && s_axi_wready;

   assign reg_wr_en   = (aw_full || aw_fire) && (w_full || w_fire);
   assign reg_wr_addr = aw_full ? aw_addr_q : s_axi_awaddr;
   assign reg_wr_data = w_full ? w_data_q : s_axi_wdata;
   assign reg_wr_strb = w_full ? w_strb_q : s_axi_wstrb;
   assign s_axi_bresp = 2'b00;

   assign s_axi_arready = !s_axi_rvalid;
   assign ar_fire       = s_axi_arvalid && s_axi_arready;
   assign reg_rd_addr   = s_axi_araddr;
   assign s_axi_rresp   = 2'b00;

   always_ff @(posedge clk or negedge sys__srstn) begin
      if (!sys__srstn) begin
         aw_full      <= 1'b0;
         w_full       <= 1'b0;
         aw_addr_q    <= '0;
         w_data_q     <= '0;
         w_strb_q     <= '0;
         s_axi_bvalid <= 1'b0;
         s_axi_rvalid <= 1'b0;
         s_axi_rdata  <= '0;
      end else begin
         if (s_axi_bvalid && s_axi_bready) s_axi_bvalid <= 1'b0;
         if (reg_wr_en) begin
            aw_full      <= 1'b0;
            w_full       <= 1'b0;
            s_axi_bvalid <= 1'b1;
         end else begin
            if (aw_fire) begin
               aw_full   <= 1'b1;
               aw_addr_q <= s_axi_awaddr;
            end
            if (w_fire) begin
               w_full   <= 1'b1;
               w_data_q <= s_axi_wdata;
               w_strb_q <= s_axi_wstrb;
            end
         end
         if (ar_fire) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= reg_rd_data;
         end else if (s_axi_rvalid && s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/simple_wgen.sv
// Write-data generator: emits LEN bytes of a byte-ramp pattern as AXI
// write-data beats, controlled through an AXI4-Lite register port.
// Ports:
//   clk, arst            clock, asynchronous active-high reset
//   s_axi_ctl_*          AXI4-Lite control slave (CTRL/LEN/SENT/STATUS)
//   p_axi_w*             generated write-data channel (valid/ready)
//   dbg_state            current generator FSM state
module simple_wgen
   import simple_wgen_pkg::*;
#(
   parameter int axi_addr_width   = 32,
   parameter int p_axi_data_width = 128
) (
   input  logic                          clk,
   input  logic                          arst,
   input  logic [axi_addr_width-1:0]     s_axi_ctl_awaddr,
   input  logic                          s_axi_ctl_awvalid,
   output logic                          s_axi_ctl_awready,
   input  logic [31:0]                   s_axi_ctl_wdata,
   input  logic [3:0]                    s_axi_ctl_wstrb,
   input  logic                          s_axi_ctl_wvalid,
   output logic                          s_axi_ctl_wready,
   output logic [1:0]                    s_axi_ctl_bresp,
   output logic                          s_axi_ctl_bvalid,
   input  logic                          s_axi_ctl_bready,
   input  logic [axi_addr_width-1:0]     s_axi_ctl_araddr,
   input  logic                          s_axi_ctl_arvalid,
   output logic                          s_axi_ctl_arready,
   output logic [31:0]                   s_axi_ctl_rdata,
   output logic [1:0]                    s_axi_ctl_rresp,
   output logic                          s_axi_ctl_rvalid,
   input  logic                          s_axi_ctl_rready,
   output logic [p_axi_data_width-1:0]   p_axi_wdata,
   output logic [p_axi_data_width/8-1:0] p_axi_wstrb,
   output logic                          p_axi_wvalid,
   output logic                          p_axi_wlast,
   input  logic                          p_axi_wready,
   output state_t                        dbg_state
);

   localparam int          BPB   = p_axi_data_width / 8;
   localparam logic [31:0] BPB_W = 32'(BPB);

   logic                      reg_wr_en;
   logic [axi_addr_width-1:0] reg_wr_addr, reg_rd_addr;
   logic [31:0]               reg_wr_data, reg_rd_data;
   logic [3:0]                reg_wr_strb;
   logic                      sif_srstn;

   state_t      state_q;
   logic [31:0] len_q, sent_q, remaining_q;
   logic        done_q, aborted_q, abort_pend_q;

   logic                        start_req, abort_req, len_wr, hs;
   logic [31:0]                 beat_bytes, nb_sent, nb_rem;
   logic [p_axi_data_width-1:0] nb_data;
   logic [BPB-1:0]              nb_strb;
   logic                        nb_last;
   logic                        unused_addr_bits;

   assign sif_srstn = ~arst;

   axi4l_sif #(.addr_width(axi_addr_width)) u_sif (
      .clk           (clk),
      .sys__srstn    (sif_srstn),
      .s_axi_awaddr  (s_axi_ctl_awaddr),
      .s_axi_awvalid (s_axi_ctl_awvalid),
      .s_axi_awready (s_axi_ctl_awready),
      .s_axi_wdata   (s_axi_ctl_wdata),
      .s_axi_wstrb   (s_axi_ctl_wstrb),
      .s_axi_wvalid  (s_axi_ctl_wvalid),
      .s_axi_wready  (s_axi_ctl_wready),
      .s_axi_bresp   (s_axi_ctl_bresp),
      .s_axi_bvalid  (s_axi_ctl_bvalid),
      .s_axi_bready  (s_axi_ctl_bready),
      .s_axi_araddr  (s_axi_ctl_araddr),
      .s_axi_arvalid (s_axi_ctl_arvalid),
      .s_axi_arready (s_axi_ctl_arready),
      .s_axi_rdata   (s_axi_ctl_rdata),
      .s_axi_rresp   (s_axi_ctl_rresp),
      .s_axi_rvalid  (s_axi_ctl_rvalid),
      .s_axi_rready  (s_axi_ctl_rready),
      .reg_wr_en     (reg_wr_en),
      .reg_wr_addr   (reg_wr_addr),
      .reg_wr_data   (reg_wr_data),
      .reg_wr_strb   (reg_wr_strb),
      .reg_rd_addr   (reg_rd_addr),
      .reg_rd_data   (reg_rd_data)
   );

   // Only address bits [3:2] select a register.
   assign unused_addr_bits = ^{reg_wr_addr[axi_addr_width-1:4], reg_wr_addr[1:0],
                               reg_rd_addr[axi_addr_width-1:4], reg_rd_addr[1:0]};

   assign start_req = reg_wr_en && (reg_wr_addr[3:2] == REG_CTRL) && reg_wr_strb[0]
                      && reg_wr_data[CTRL_START_BIT];
   assign abort_req = reg_wr_en && (reg_wr_addr[3:2] == REG_CTRL) && reg_wr_strb[0]
                      && reg_wr_data[CTRL_ABORT_BIT];
   assign len_wr    = reg_wr_en && (reg_wr_addr[3:2] == REG_LEN) && (state_q == ST_IDLE);
   assign hs        = p_axi_wvalid && p_axi_wready;

   // popcount(wstrb) of the current beat: full beat unless it is the last
   assign beat_bytes = p_axi_wlast ? remaining_q : BPB_W;

   // Next beat, built from the byte position it starts at: offset 0 of LEN
   // when starting from IDLE, otherwise the position after this handshake.
   always_comb begin
      nb_sent = 32'd0;
      nb_rem  = len_q;
      if (state_q == ST_SEND) begin
         nb_sent = sent_q + beat_bytes;
         nb_rem  = remaining_q - beat_bytes;
      end
      nb_data = '0;
      nb_strb = '0;
      for (int j = 0; j < BPB; j++) begin
         nb_data[8*j +: 8] = nb_sent[7:0] + 8'(j);
         nb_strb[j]        = (nb_rem > 32'(j));
      end
      nb_last = (nb_rem <= BPB_W);
   end

   always_comb begin
      reg_rd_data = 32'd0;
      case (reg_rd_addr[3:2])
         REG_LEN:    reg_rd_data = len_q;
         REG_SENT:   reg_rd_data = sent_q;
         REG_STATUS: begin
            reg_rd_data[STAT_BUSY_BIT]    = (state_q == ST_SEND);
            reg_rd_data[STAT_DONE_BIT]    = done_q;
            reg_rd_data[STAT_ABORTED_BIT] = aborted_q;
         end
         default:    reg_rd_data = 32'd0;
      endcase
   end

   assign dbg_state = state_q;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q      <= ST_IDLE;
         len_q        <= '0;
         sent_q       <= '0;
         remaining_q  <= '0;
         done_q       <= 1'b0;
         aborted_q    <= 1'b0;
         abort_pend_q <= 1'b0;
         p_axi_wdata  <= '0;
         p_axi_wstrb  <= '0;
         p_axi_wvalid <= 1'b0;
         p_axi_wlast  <= 1'b0;
      end else begin
         if (len_wr) begin
            for (int b = 0; b < 4; b++)
               if (reg_wr_strb[b]) len_q[8*b +: 8] <= reg_wr_data[8*b +: 8];
         end
         case (state_q)
            ST_IDLE: begin
               // start together with abort counts as abort, which is a no-op here
               if (start_req && !abort_req) begin
                  sent_q    <= '0;
                  aborted_q <= 1'b0;
                  if (len_q != 32'd0) begin
                     state_q      <= ST_SEND;
                     remaining_q  <= len_q;
                     done_q       <= 1'b0;
                     abort_pend_q <= 1'b0;
                     p_axi_wvalid <= 1'b1;
                     p_axi_wdata  <= nb_data;
                     p_axi_wstrb  <= nb_strb;
                     p_axi_wlast  <= nb_last;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            ST_SEND: begin
               // an abort never retracts an offered beat; it is remembered
               // and takes effect when that beat is accepted
               if (abort_req) abort_pend_q <= 1'b1;
               if (hs) begin
                  sent_q      <= nb_sent;
                  remaining_q <= nb_rem;
                  if (p_axi_wlast || abort_pend_q || abort_req) begin
                     state_q      <= ST_IDLE;
                     p_axi_wvalid <= 1'b0;
                     p_axi_wlast  <= 1'b0;
                     p_axi_wstrb  <= '0;
                     abort_pend_q <= 1'b0;
                     if (abort_pend_q || abort_req) aborted_q <= 1'b1;
                     else                           done_q    <= 1'b1;
                  end else begin
                     p_axi_wdata <= nb_data;
                     p_axi_wstrb <= nb_strb;
                     p_axi_wlast <= nb_last;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_simple_wgen.sv
module tb_simple_wgen;
   import simple_wgen_pkg::*;

   localparam int AW  = 32;
   localparam int DW  = 128;
   localparam int BPB = DW / 8;

   localparam logic [31:0] A_CTRL   = 32'h0;
   localparam logic [31:0] A_LEN    = 32'h4;
   localparam logic [31:0] A_SENT   = 32'h8;
   localparam logic [31:0] A_STATUS = 32'hC;

   logic           clk = 1'b0;
   logic           arst;
   logic [AW-1:0]  awaddr, araddr;
   logic           awvalid, awready, wvalid, wready, bvalid, bready;
   logic [31:0]    wdata, rdata;
   logic [3:0]     wstrb;
   logic [1:0]     bresp, rresp;
   logic           arvalid, arready, rvalid, rready;
   logic [DW-1:0]  p_wdata;
   logic [BPB-1:0] p_wstrb;
   logic           p_wvalid, p_wlast, p_wready;
   state_t         dbg_state;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [DW-1:0]  mon_data_q[$];
   logic [BPB-1:0] mon_strb_q[$];
   logic           mon_last_q[$];
   int             mon_cyc_q[$];

   simple_wgen #(.axi_addr_width(AW), .p_axi_data_width(DW)) dut (
      .clk               (clk),
      .arst              (arst),
      .s_axi_ctl_awaddr  (awaddr),
      .s_axi_ctl_awvalid (awvalid),
      .s_axi_ctl_awready (awready),
      .s_axi_ctl_wdata   (wdata),
      .s_axi_ctl_wstrb   (wstrb),
      .s_axi_ctl_wvalid  (wvalid),
      .s_axi_ctl_wready  (wready),
      .s_axi_ctl_bresp   (bresp),
      .s_axi_ctl_bvalid  (bvalid),
      .s_axi_ctl_bready  (bready),
      .s_axi_ctl_araddr  (araddr),
      .s_axi_ctl_arvalid (arvalid),
      .s_axi_ctl_arready (arready),
      .s_axi_ctl_rdata   (rdata),
      .s_axi_ctl_rresp   (rresp),
      .s_axi_ctl_rvalid  (rvalid),
      .s_axi_ctl_rready  (rready),
      .p_axi_wdata       (p_wdata),
      .p_axi_wstrb       (p_wstrb),
      .p_axi_wvalid      (p_wvalid),
      .p_axi_wlast       (p_wlast),
      .p_axi_wready      (p_wready),
      .dbg_state         (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // beat recorder: a beat is accepted on the edge after a negedge that sees valid && ready
   always @(negedge clk) begin
      if (!arst && p_wvalid && p_wready) begin
         mon_data_q.push_back(p_wdata);
         mon_strb_q.push_back(p_wstrb);
         mon_last_q.push_back(p_wlast);
         mon_cyc_q.push_back(cyc);
      end
   end

   function automatic logic [DW-1:0] lane_ramp(input int base);
      logic [DW-1:0] r;
      r = '0;
      for (int j = 0; j < BPB; j++) r[8*j +: 8] = 8'(base + j);
      return r;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_beats();
      mon_data_q.delete();
      mon_strb_q.delete();
      mon_last_q.delete();
      mon_cyc_q.delete();
   endtask

   // driver tasks
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
      bit aw_ok, w_ok, a_rdy, w_rdy;
      int n;
      awaddr = addr; wdata = data; wstrb = strb;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      aw_ok = 1'b0; w_ok = 1'b0; n = 0;
      while (!(aw_ok && w_ok) && n < 20) begin
         a_rdy = awready;
         w_rdy = wready;
         tick(1);
         n++;
         if (awvalid && a_rdy) begin aw_ok = 1'b1; awvalid = 1'b0; end
         if (wvalid && w_rdy)  begin w_ok = 1'b1;  wvalid = 1'b0;  end
      end
      n = 0;
      while (!bvalid && n < 20) begin tick(1); n++; end
      total++;
      if (!aw_ok || !w_ok || !bvalid || bresp !== 2'b00) begin
         bad++;
         $display("FAIL axi_write addr=%h: aw=%0d w=%0d bvalid=%0d bresp=%0d, required handshakes and OKAY",
                  addr, aw_ok, w_ok, bvalid, bresp);
         awvalid = 1'b0; wvalid = 1'b0;
      end else begin
         tick(1);
      end
      bready = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
      bit a_rdy, ar_ok;
      int n;
      araddr = addr; arvalid = 1'b1; rready = 1'b1;
      ar_ok = 1'b0; n = 0;
      while (!ar_ok && n < 20) begin
         a_rdy = arready;
         tick(1);
         n++;
         if (a_rdy) ar_ok = 1'b1;
      end
      arvalid = 1'b0;
      n = 0;
      while (!rvalid && n < 20) begin tick(1); n++; end
      data = rdata;
      total++;
      if (!ar_ok || !rvalid || rresp !== 2'b00) begin
         bad++;
         $display("FAIL axi_read addr=%h: ar=%0d rvalid=%0d rresp=%0d", addr, ar_ok, rvalid, rresp);
         data = 32'hxxxx_xxxx;
      end else begin
         tick(1);
      end
      rready = 1'b0;
   endtask

   task automatic wait_wvalid_low(input int max_cyc);
      int n;
      n = 0;
      while (p_wvalid && n < max_cyc) begin tick(1); n++; end
      total++;
      if (p_wvalid) begin
         bad++;
         $display("FAIL wvalid_timeout: wvalid still 1 after %0d cycles, required 0", max_cyc);
      end
   endtask

   // tests
   task automatic test_reset();
      logic [31:0] v;
      total++;
      if (p_wvalid !== 1'b0 || p_wlast !== 1'b0 || p_wstrb !== '0 || p_wdata !== '0) begin
         bad++;
         $display("FAIL reset_outputs: wvalid=%0d wlast=%0d wstrb=%h wdata=%h, required all 0",
                  p_wvalid, p_wlast, p_wstrb, p_wdata);
      end
      total++;
      if (bvalid !== 1'b0 || rvalid !== 1'b0 || dbg_state !== ST_IDLE) begin
         bad++;
         $display("FAIL reset_ctl: bvalid=%0d rvalid=%0d state=%0d, required 0 0 IDLE",
                  bvalid, rvalid, dbg_state);
      end
      axi_read(A_LEN, v);
      total++;
      if (v !== 32'd0) begin bad++; $display("FAIL reset_len: got %h required 0", v); end
      axi_read(A_SENT, v);
      total++;
      if (v !== 32'd0) begin bad++; $display("FAIL reset_sent: got %h required 0", v); end
      axi_read(A_STATUS, v);
      total++;
      if (v !== 32'd0) begin bad++; $display("FAIL reset_status: got %h required 0", v); end
   endtask

   task automatic test_len_strobe();
      logic [31:0] v;
      axi_write(A_LEN, 32'hAABB_CCDD, 4'b1111);
      axi_write(A_LEN, 32'h1122_3344, 4'b0101);
      axi_read(A_LEN, v);
      total++;
      if (v !== 32'hAA22_CC44) begin bad++; $display("FAIL len_strobe: got %h required aa22cc44", v); end
      axi_read(A_CTRL, v);
      total++;
      if (v !== 32'd0) begin bad++; $display("FAIL ctrl_read: got %h required 0", v); end
   endtask

   task automatic test_basic();
      logic [31:0]    v;
      logic [BPB-1:0] exp_strb[3];
      logic           exp_last[3];
      exp_strb = '{16'hFFFF, 16'hFFFF, 16'h00FF};
      exp_last = '{1'b0, 1'b0, 1'b1};
      p_wready = 1'b1;
      axi_write(A_LEN, 32'd40, 4'hF);
      clear_beats();
      axi_write(A_CTRL, 32'h1, 4'hF);
      wait_wvalid_low(20);
      tick(2);
      total++;
      if (mon_data_q.size() !== 3) begin
         bad++;
         $display("FAIL basic_beats: got %0d beats required 3", mon_data_q.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            total++;
            if (mon_strb_q[k] !== exp_strb[k] || mon_last_q[k] !== exp_last[k]
                || mon_data_q[k] !== lane_ramp(16 * k)) begin
               bad++;
               $display("FAIL basic_beat%0d: strb=%h last=%0d data=%h required strb=%h last=%0d data=%h",
                        k, mon_strb_q[k], mon_last_q[k], mon_data_q[k],
                        exp_strb[k], exp_last[k], lane_ramp(16 * k));
            end
         end
         total++;
         if (mon_cyc_q[2] - mon_cyc_q[0] !== 2) begin
            bad++;
            $display("FAIL back_to_back: beats span %0d cycles required 2", mon_cyc_q[2] - mon_cyc_q[0]);
         end
      end
      axi_read(A_SENT, v);
      total++;
      if (v !== 32'd40) begin bad++; $display("FAIL basic_sent: got %0d required 40", v); end
      axi_read(A_STATUS, v);
      total++;
      if (v !== 32'h2) begin bad++; $display("FAIL basic_status: got %h required 2", v); end
      p_wready = 1'b0;
   endtask

   task automatic test_stall();
      logic [31:0]    v;
      logic [DW-1:0]  hd;
      logic [BPB-1:0] hst;
      bit             held;
      p_wready = 1'b0;
      axi_write(A_LEN, 32'd32, 4'hF);
      clear_beats();
      axi_write(A_CTRL, 32'h1, 4'hF);
      held = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (!p_wvalid) break;
         if (held) begin
            total++;
            if (p_wdata !== hd || p_wstrb !== hst) begin
               bad++;
               $display("FAIL stall_stable: data=%h strb=%h required data=%h strb=%h",
                        p_wdata, p_wstrb, hd, hst);
            end
         end
         p_wready = (c % 3 == 2);
         held = !p_wready;
         hd = p_wdata;
         hst = p_wstrb;
         tick(1);
      end
      p_wready = 1'b0;
      total++;
      if (mon_data_q.size() !== 2) begin
         bad++;
         $display("FAIL stall_beats: got %0d beats required 2", mon_data_q.size());
      end else begin
         total++;
         if (mon_strb_q[0] !== 16'hFFFF || mon_last_q[0] !== 1'b0 || mon_data_q[0] !== lane_ramp(0)
             || mon_strb_q[1] !== 16'hFFFF || mon_last_q[1] !== 1'b1 || mon_data_q[1] !== lane_ramp(16)) begin
            bad++;
            $display("FAIL stall_content: strb=%h/%h last=%0d/%0d data1=%h required ffff/ffff 0/1 data1=%h",
                     mon_strb_q[0], mon_strb_q[1], mon_last_q[0], mon_last_q[1], mon_data_q[1], lane_ramp(16));
         end
      end
      axi_read(A_SENT, v);
      total++;
      if (v !== 32'd32) begin bad++; $display("FAIL stall_sent: got %0d required 32", v); end
   endtask

   task automatic test_zero_len();
      logic [31:0] v;
      p_wready = 1'b1;
      axi_write(A_LEN, 32'd0, 4'hF);
      clear_beats();
      axi_write(A_CTRL, 32'h1, 4'hF);
      tick(5);
      total++;
      if (mon_data_q.size() !== 0 || p_wvalid !== 1'b0) begin
         bad++;
         $display("FAIL zero_beats: got %0d beats wvalid=%0d required 0 0", mon_data_q.size(), p_wvalid);
      end
      axi_read(A_SENT, v);
      total++;
      if (v !== 32'd0) begin bad++; $display("FAIL zero_sent: got %0d required 0", v); end
      axi_read(A_STATUS, v);
      total++;
      if (v !== 32'h2) begin bad++; $display("FAIL zero_status: got %h required 2", v); end
      p_wready = 1'b0;
   endtask

   task automatic test_abort();
      logic [31:0] v;
      p_wready = 1'b0;
      axi_write(A_LEN, 32'd1000, 4'hF);
      clear_beats();
      axi_write(A_CTRL, 32'h1, 4'hF);
      tick(3);
      axi_write(A_CTRL, 32'h2, 4'hF);
      total++;
      if (p_wvalid !== 1'b1) begin bad++; $display("FAIL abort_hold: wvalid=%0d required 1", p_wvalid); end
      p_wready = 1'b1;
      tick(10);
      p_wready = 1'b0;
      total++;
      if (mon_data_q.size() !== 1) begin
         bad++;
         $display("FAIL abort_beats: got %0d beats required 1", mon_data_q.size());
      end else begin
         total++;
         if (mon_strb_q[0] !== 16'hFFFF || mon_last_q[0] !== 1'b0 || mon_data_q[0] !== lane_ramp(0)) begin
            bad++;
            $display("FAIL abort_beat: strb=%h last=%0d data=%h required ffff 0 %h",
                     mon_strb_q[0], mon_last_q[0], mon_data_q[0], lane_ramp(0));
         end
      end
      axi_read(A_SENT, v);
      total++;
      if (v !== 32'd16) begin bad++; $display("FAIL abort_sent: got %0d required 16", v); end
      axi_read(A_STATUS, v);
      total++;
      if (v !== 32'h4) begin bad++; $display("FAIL abort_status: got %h required 4", v); end
   endtask

   task automatic test_busy_ignore();
      logic [31:0] v;
      p_wready = 1'b0;
      axi_write(A_LEN, 32'd48, 4'hF);
      clear_beats();
      axi_write(A_CTRL, 32'h1, 4'hF);
      tick(2);
      axi_write(A_LEN, 32'd16, 4'hF);
      axi_write(A_CTRL, 32'h1, 4'hF);
      axi_read(A_LEN, v);
      total++;
      if (v !== 32'd48) begin bad++; $display("FAIL busy_len: got %0d required 48", v); end
      axi_read(A_STATUS, v);
      total++;
      if (v !== 32'h1) begin bad++; $display("FAIL busy_status: got %h required 1", v); end
      p_wready = 1'b1;
      wait_wvalid_low(20);
      tick(2);
      p_wready = 1'b0;
      total++;
      if (mon_data_q.size() !== 3 || mon_last_q[mon_last_q.size()-1] !== 1'b1
          || mon_strb_q[mon_strb_q.size()-1] !== 16'hFFFF) begin
         bad++;
         $display("FAIL busy_beats: got %0d beats required 3 ending in full strobe with wlast",
                  mon_data_q.size());
      end
      axi_read(A_SENT, v);
      total++;
      if (v !== 32'd48) begin bad++; $display("FAIL busy_sent: got %0d required 48", v); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] v;
      p_wready = 1'b0;
      axi_write(A_LEN, 32'd1000, 4'hF);
      axi_write(A_CTRL, 32'h1, 4'hF);
      tick(2);
      total++;
      if (p_wvalid !== 1'b1) begin bad++; $display("FAIL rst_pre: wvalid=%0d required 1", p_wvalid); end
      arst = 1'b1;
      #1;
      total++;
      if (p_wvalid !== 1'b0 || p_wstrb !== '0 || p_wdata !== '0 || p_wlast !== 1'b0) begin
         bad++;
         $display("FAIL rst_async: wvalid=%0d wstrb=%h wdata=%h wlast=%0d required all 0",
                  p_wvalid, p_wstrb, p_wdata, p_wlast);
      end
      tick(2);
      arst = 1'b0;
      p_wready = 1'b1;
      clear_beats();
      tick(5);
      total++;
      if (mon_data_q.size() !== 0) begin
         bad++;
         $display("FAIL rst_resume: got %0d beats after release required 0", mon_data_q.size());
      end
      axi_read(A_LEN, v);
      total++;
      if (v !== 32'd0) begin bad++; $display("FAIL rst_len: got %h required 0", v); end
      axi_read(A_SENT, v);
      total++;
      if (v !== 32'd0) begin bad++; $display("FAIL rst_sent: got %h required 0", v); end
      axi_read(A_STATUS, v);
      total++;
      if (v !== 32'd0) begin bad++; $display("FAIL rst_status: got %h required 0", v); end
      axi_write(A_LEN, 32'd20, 4'hF);
      clear_beats();
      axi_write(A_CTRL, 32'h1, 4'hF);
      wait_wvalid_low(20);
      tick(2);
      p_wready = 1'b0;
      total++;
      if (mon_data_q.size() !== 2) begin
         bad++;
         $display("FAIL fresh_beats: got %0d beats required 2", mon_data_q.size());
      end else begin
         total++;
         if (mon_strb_q[0] !== 16'hFFFF || mon_strb_q[1] !== 16'h000F || mon_last_q[1] !== 1'b1
             || mon_data_q[1] !== lane_ramp(16)) begin
            bad++;
            $display("FAIL fresh_content: strb=%h/%h last=%0d data1=%h required ffff/000f 1 %h",
                     mon_strb_q[0], mon_strb_q[1], mon_last_q[1], mon_data_q[1], lane_ramp(16));
         end
      end
      axi_read(A_STATUS, v);
      total++;
      if (v !== 32'h2) begin bad++; $display("FAIL fresh_status: got %h required 2", v); end
   endtask

   initial begin
      arst = 1'b1;
      awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
      araddr = '0; arvalid = 1'b0; rready = 1'b0; p_wready = 1'b0;
      tick(3);
      arst = 1'b0;
      tick(1);
      test_reset();
      test_len_strobe();
      test_basic();
      test_stall();
      test_zero_len();
      test_abort();
      test_busy_ignore();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
